// File: rtl/demux_c.sv
// 1:2 burst demultiplexer: the first beat of each burst selects the lane, and
// each lane buffers its bytes in a small FIFO until the downstream consumer pops them.
module demux_c #(
  parameter int DATA_W      = 8,
  parameter int ROUTE_BIT   = 7,
  parameter int FIFO_DEPTH  = 4,
  parameter int ALMOST_FULL = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in_c,
  input  logic              valid_in_c,
  output logic              pause_c,
  input  logic              pop_0_c,
  input  logic              pop_1_c,
  output logic [DATA_W-1:0] data_out_0_c,
  output logic              valid_out_0_c,
  output logic [DATA_W-1:0] data_out_1_c,
  output logic              valid_out_1_c,
  output logic              empty_0_c,
  output logic              empty_1_c,
  output logic              drop_err_c
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX_0 = 2'd1,
    RX_1 = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [1:0] push_req;
  logic [1:0] push_ok;
  logic [1:0] pop_req;
  logic [1:0] pop_ok;
  logic [1:0] empty;
  logic [1:0] almost_full;
  logic       drop_err;

  assign pop_req = {pop_1_c, pop_0_c};

  // Route decision: only IDLE looks at the route bit; a valid gap ends the burst.
  always_comb begin
    state_nx = IDLE;
    push_req = '0;
    if (valid_in_c) begin
      unique case (state)
        IDLE: begin
          if (data_in_c[ROUTE_BIT]) begin
            push_req = 2'b10;
            state_nx = RX_1;
          end else begin
            push_req = 2'b01;
            state_nx = RX_0;
          end
        end
        RX_0: begin
          push_req = 2'b01;
          state_nx = RX_0;
        end
        RX_1: begin
          push_req = 2'b10;
          state_nx = RX_1;
        end
        default: begin
          push_req = '0;
          state_nx = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      drop_err <= 1'b0;
    end else begin
      state <= state_nx;
      if ((push_req & ~push_ok) != 2'b00)
        drop_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] dout;
    logic              vout;

    assign pop_ok[g]      = pop_req[g] && (count != '0);
    // A same-cycle pop frees the slot, so a full lane can still take the byte.
    assign push_ok[g]     = push_req[g] && ((count < CNT_W'(FIFO_DEPTH)) || pop_ok[g]);
    assign empty[g]       = (count == '0);
    assign almost_full[g] = (count >= CNT_W'(ALMOST_FULL));

    always_ff @(posedge clk) begin
      if (push_ok[g])
        mem[wr_ptr] <= data_in_c;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        dout   <= '0;
        vout   <= 1'b0;
      end else begin
        vout <= pop_ok[g];
        if (pop_ok[g]) begin
          dout   <= mem[rd_ptr];
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push_ok[g])
          wr_ptr <= wr_ptr + PTR_W'(1);
        unique case ({push_ok[g], pop_ok[g]})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign data_out_0_c  = g_lane[0].dout;
  assign valid_out_0_c = g_lane[0].vout;
  assign data_out_1_c  = g_lane[1].dout;
  assign valid_out_1_c = g_lane[1].vout;
  assign empty_0_c     = empty[0];
  assign empty_1_c     = empty[1];
  assign pause_c       = |almost_full;
  assign drop_err_c    = drop_err;

endmodule

// File: tb/tb_demux_c.sv
// Randomized scoreboard bench for demux_c: a queue-based lane model predicts
// every popped byte and the status flags; a monitor compares DUT outputs.
module tb_demux_c;

  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in_c = '0;
  logic       valid_in_c = 1'b0;
  logic       pop_0_c = 1'b0;
  logic       pop_1_c = 1'b0;
  logic       pause_c;
  logic [7:0] data_out_0_c, data_out_1_c;
  logic       valid_out_0_c, valid_out_1_c;
  logic       empty_0_c, empty_1_c;
  logic       drop_err_c;

  demux_c #(.DATA_W(8), .ROUTE_BIT(7), .FIFO_DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
    .clk(clk), .reset(reset),
    .data_in_c(data_in_c), .valid_in_c(valid_in_c), .pause_c(pause_c),
    .pop_0_c(pop_0_c), .pop_1_c(pop_1_c),
    .data_out_0_c(data_out_0_c), .valid_out_0_c(valid_out_0_c),
    .data_out_1_c(data_out_1_c), .valid_out_1_c(valid_out_1_c),
    .empty_0_c(empty_0_c), .empty_1_c(empty_1_c),
    .drop_err_c(drop_err_c)
  );

  always #5 clk = ~clk;

  // Reference model: lane contents as queues, burst lane as -1 (none) / 0 / 1.
  logic [7:0] lane_q0[$], lane_q1[$];
  logic [7:0] exp_q0[$], exp_q1[$];
  int         cur_lane = -1;
  bit         m_drop = 0;
  logic [7:0] m_last0 = '0, m_last1 = '0;
  bit         done = 0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and advance the model to the state after the next edge.
  task automatic cycle(input bit rst, input bit v, input logic [7:0] d, input bit p0, input bit p1);
    int lane;
    @(negedge clk);
    reset = rst; valid_in_c = v; data_in_c = d; pop_0_c = p0; pop_1_c = p1;
    if (rst) begin
      lane_q0.delete(); lane_q1.delete();
      cur_lane = -1; m_drop = 0; m_last0 = '0; m_last1 = '0;
    end else begin
      if (p0 && lane_q0.size() > 0) begin
        m_last0 = lane_q0.pop_front();
        exp_q0.push_back(m_last0);
      end
      if (p1 && lane_q1.size() > 0) begin
        m_last1 = lane_q1.pop_front();
        exp_q1.push_back(m_last1);
      end
      if (v) begin
        lane = (cur_lane < 0) ? int'(d[7]) : cur_lane;
        if (lane == 0) begin
          if (lane_q0.size() < DEPTH) lane_q0.push_back(d); else m_drop = 1;
        end else begin
          if (lane_q1.size() < DEPTH) lane_q1.push_back(d); else m_drop = 1;
        end
        cur_lane = lane;
      end else begin
        cur_lane = -1;
      end
    end
  endtask

  // Monitor: all comparisons live here, sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (valid_out_0_c) begin
        if (exp_q0.size() == 0) chk("lane0_spurious_valid", 1, 0);
        else chk("lane0_data", {24'h0, data_out_0_c}, {24'h0, exp_q0.pop_front()});
      end else if (exp_q0.size() != 0) begin
        chk("lane0_missing_valid", 0, 1);
        void'(exp_q0.pop_front());
      end
      if (valid_out_1_c) begin
        if (exp_q1.size() == 0) chk("lane1_spurious_valid", 1, 0);
        else chk("lane1_data", {24'h0, data_out_1_c}, {24'h0, exp_q1.pop_front()});
      end else if (exp_q1.size() != 0) begin
        chk("lane1_missing_valid", 0, 1);
        void'(exp_q1.pop_front());
      end
      chk("lane0_hold", {24'h0, data_out_0_c}, {24'h0, m_last0});
      chk("lane1_hold", {24'h0, data_out_1_c}, {24'h0, m_last1});
      chk("empty0", empty_0_c, lane_q0.size() == 0);
      chk("empty1", empty_1_c, lane_q1.size() == 0);
      chk("pause", pause_c, (lane_q0.size() >= AF) || (lane_q1.size() >= AF));
      chk("drop_err", drop_err_c, m_drop);
      if (done) begin
        chk("exp_q0_drained", exp_q0.size(), 0);
        chk("exp_q1_drained", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    bit v, p0, p1;
    // 1: reset held for two cycles
    cycle(1, 0, 8'h00, 0, 0);
    cycle(1, 0, 8'h00, 0, 0);
    // 2: lane0 burst, then three pops
    cycle(0, 1, 8'h05, 0, 0);
    cycle(0, 1, 8'h06, 0, 0);
    cycle(0, 1, 8'h07, 0, 0);
    cycle(0, 0, 8'h00, 0, 0);
    repeat (3) cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 0, 8'h00, 1, 1);
    // 3: route bit only matters on the first beat
    cycle(0, 1, 8'h81, 0, 0);
    cycle(0, 1, 8'h02, 0, 0);
    cycle(0, 1, 8'h03, 0, 0);
    cycle(0, 0, 8'h00, 0, 0);
    repeat (3) cycle(0, 0, 8'h00, 0, 1);
    // 4: overfill lane0, drop on the fifth beat, then drain
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'h10 + 8'(i), 0, 0);
    cycle(0, 0, 8'h00, 0, 0);
    repeat (5) cycle(0, 0, 8'h00, 1, 0);
    // 5: full lane with simultaneous push and pop
    cycle(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h20 + 8'(i), 0, 0);
    cycle(0, 1, 8'h24, 1, 0);
    cycle(0, 0, 8'h00, 0, 0);
    repeat (5) cycle(0, 0, 8'h00, 1, 0);
    // 6: reset mid-burst, next burst routes on its own first beat
    cycle(0, 1, 8'h31, 0, 0);
    cycle(0, 1, 8'h32, 0, 0);
    cycle(1, 1, 8'h33, 0, 0);
    cycle(0, 1, 8'hB4, 0, 0);
    cycle(0, 1, 8'h35, 0, 0);
    cycle(0, 0, 8'h00, 0, 0);
    repeat (3) cycle(0, 0, 8'h00, 1, 1);
    // Random traffic with varying burst and pop densities
    v = 0;
    for (int i = 0; i < 3000; i++) begin
      if (v) v = ($urandom_range(0, 9) < 8);
      else   v = ($urandom_range(0, 9) < 4);
      p0 = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 3 : 7));
      p1 = ($urandom_range(0, 9) < ((i / 700) % 2 == 0 ? 6 : 2));
      cycle(($urandom_range(0, 299) == 0), v, 8'($urandom), p0, p1);
    end
    cycle(0, 0, 8'h00, 0, 0);
    repeat (6) cycle(0, 0, 8'h00, 1, 1);
    @(negedge clk);
    done = 1;
  end

endmodule
